// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared definitions for the pipelined floating-point multiplier.
//   fp_class_t  - special-case class carried down the pipeline
//   exp_bias    - IEEE-style exponent bias for a given exponent width
//   exp_max     - all-ones biased exponent (Inf/NaN encoding)
//   canon_nan   - canonical quiet NaN word {0, all-ones, 1<<(MAN_W-1)}
//                 returned in 64 bits; callers cast to their word width.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned exp_max(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    function automatic logic [63:0] canon_nan(input int unsigned exp_w,
                                              input int unsigned man_w);
        logic [63:0] w;
        w = (64'(exp_max(exp_w)) << man_w) | (64'd1 << (man_w - 32'd1));
        return w;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational normalise + round-to-nearest-even + range check.
//   prod_i      - full significand product {1.f}*{1.f}, 2*MAN_W+2 bits
//   exp_i       - biased exponent sum (ea+eb-bias), EXP_W+2 bits, two's complement
//   frac_o      - rounded fraction field
//   exp_o       - low EXP_W bits of the final biased exponent
//   overflow_o  - final exponent >= all-ones (result must become Inf)
//   underflow_o - final exponent <= 0 (result must become zero)
module fp_round_rne
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic [2*MAN_W+1:0] prod_i,
    input  logic [EXP_W+1:0]   exp_i,
    output logic [MAN_W-1:0]   frac_o,
    output logic [EXP_W-1:0]   exp_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int unsigned P_W = 2 * MAN_W + 2;
    localparam int unsigned E_W = EXP_W + 2;
    localparam logic [E_W-1:0] EXP_ALL_ONES = E_W'(exp_max(EXP_W));

    logic                 norm;
    logic [P_W-2:0]       shifted;   // product with the leading one dropped
    logic [MAN_W-1:0]     frac_t;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic [MAN_W:0]       frac_r;
    logic                 carry;
    logic [E_W-1:0]       e_fin;

    always_comb begin
        norm = prod_i[P_W-1];
        // Align so the leading one sits just above bit P_W-2 either way.
        shifted = norm ? prod_i[P_W-2:0] : {prod_i[P_W-3:0], 1'b0};

        frac_t = shifted[P_W-2 -: MAN_W];
        guard  = shifted[MAN_W];
        sticky = |shifted[MAN_W-1:0];
        inc    = guard && (sticky || frac_t[0]);

        // On carry-out the low bits are already zero, so frac_r[MAN_W-1:0]
        // is the correct post-carry fraction without an explicit clear.
        frac_r = {1'b0, frac_t} + (MAN_W+1)'(inc);
        carry  = frac_r[MAN_W];
        frac_o = frac_r[MAN_W-1:0];

        e_fin = exp_i + E_W'(norm) + E_W'(carry);
        exp_o = e_fin[EXP_W-1:0];

        // e_fin is signed; the MSB marks a negative exponent.
        overflow_o  = !e_fin[E_W-1] && (e_fin >= EXP_ALL_ONES);
        underflow_o = e_fin[E_W-1] || (e_fin == '0);
    end

endmodule

// File: rtl/fp_mul.sv
// fp_mul_pipe: 3-stage elastic floating-point multiplier with RNE rounding.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (a_operand, b_operand)
//   out_valid/out_ready - result handshake (result, exception, overflow, underflow)
//   Stage 1: classify + exponent sum + significands
//   Stage 2: significand product
//   Stage 3: round/pack into output registers
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   exception,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned P_W = 2 * MAN_W + 2;
    localparam int unsigned E_W = EXP_W + 2;
    localparam logic [E_W-1:0] BIAS     = E_W'(exp_bias(EXP_W));
    localparam logic [W-1:0]   NAN_WORD = W'(canon_nan(EXP_W, MAN_W));

    // ---------------- stage 1 combinational decode ----------------
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    fp_class_t          in_cls;
    logic [E_W-1:0]     in_exp_sum;

    always_comb begin
        a_sign = a_operand[W-1];
        b_sign = b_operand[W-1];
        a_exp  = a_operand[W-2 -: EXP_W];
        b_exp  = b_operand[W-2 -: EXP_W];
        a_frac = a_operand[MAN_W-1:0];
        b_frac = b_operand[MAN_W-1:0];

        a_nan  = (&a_exp) && (a_frac != '0);
        b_nan  = (&b_exp) && (b_frac != '0);
        a_inf  = (&a_exp) && (a_frac == '0);
        b_inf  = (&b_exp) && (b_frac == '0);
        // Subnormals are flushed: any zero exponent counts as zero.
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            in_cls = CLS_NAN;
        end else if (a_inf || b_inf) begin
            in_cls = CLS_INF;
        end else if (a_zero || b_zero) begin
            in_cls = CLS_ZERO;
        end else begin
            in_cls = CLS_NORMAL;
        end

        in_exp_sum = E_W'(a_exp) + E_W'(b_exp) - BIAS;
    end

    // ---------------- pipeline state ----------------
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q, s1_sign_d;
    fp_class_t          s1_cls_q, s1_cls_d;
    logic [E_W-1:0]     s1_exp_q, s1_exp_d;
    logic [MAN_W:0]     s1_man_a_q, s1_man_a_d;
    logic [MAN_W:0]     s1_man_b_q, s1_man_b_d;

    logic               s2_valid_q, s2_valid_d;
    logic               s2_sign_q, s2_sign_d;
    fp_class_t          s2_cls_q, s2_cls_d;
    logic [E_W-1:0]     s2_exp_q, s2_exp_d;
    logic [P_W-1:0]     s2_prod_q, s2_prod_d;

    logic               s3_valid_q, s3_valid_d;
    logic [W-1:0]       s3_result_q, s3_result_d;
    logic               s3_exc_q, s3_exc_d;
    logic               s3_ovf_q, s3_ovf_d;
    logic               s3_unf_q, s3_unf_d;

    logic               s1_load, s2_load, s3_load, accept;

    // ---------------- stage 3 rounding ----------------
    logic [MAN_W-1:0]   rnd_frac;
    logic [EXP_W-1:0]   rnd_exp;
    logic               rnd_ovf, rnd_unf;

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod_i      (s2_prod_q),
        .exp_i       (s2_exp_q),
        .frac_o      (rnd_frac),
        .exp_o       (rnd_exp),
        .overflow_o  (rnd_ovf),
        .underflow_o (rnd_unf)
    );

    // ---------------- handshake chain ----------------
    // Each stage loads when empty or when its occupant moves on this cycle;
    // this ripples out_ready back to in_ready combinationally.
    always_comb begin
        s3_load  = !s3_valid_q || out_ready;
        s2_load  = !s2_valid_q || s3_load;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = !rst && s1_load;
        accept   = in_valid && in_ready;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // stage 1
        s1_valid_d = s1_load ? accept : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_cls_d   = s1_cls_q;
        s1_exp_d   = s1_exp_q;
        s1_man_a_d = s1_man_a_q;
        s1_man_b_d = s1_man_b_q;
        if (accept) begin
            s1_sign_d  = a_sign ^ b_sign;
            s1_cls_d   = in_cls;
            s1_exp_d   = in_exp_sum;
            s1_man_a_d = {1'b1, a_frac};
            s1_man_b_d = {1'b1, b_frac};
        end

        // stage 2
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_cls_d   = s2_cls_q;
        s2_exp_d   = s2_exp_q;
        s2_prod_d  = s2_prod_q;
        if (s2_load && s1_valid_q) begin
            s2_sign_d = s1_sign_q;
            s2_cls_d  = s1_cls_q;
            s2_exp_d  = s1_exp_q;
            s2_prod_d = P_W'(s1_man_a_q) * P_W'(s1_man_b_q);
        end

        // stage 3: output registers only change on a real load, so the
        // presented result stays stable while the consumer stalls.
        s3_valid_d  = s3_load ? s2_valid_q : s3_valid_q;
        s3_result_d = s3_result_q;
        s3_exc_d    = s3_exc_q;
        s3_ovf_d    = s3_ovf_q;
        s3_unf_d    = s3_unf_q;
        if (s3_load && s2_valid_q) begin
            s3_exc_d = 1'b0;
            s3_ovf_d = 1'b0;
            s3_unf_d = 1'b0;
            case (s2_cls_q)
                CLS_NAN: begin
                    s3_result_d = NAN_WORD;
                    s3_exc_d    = 1'b1;
                end
                CLS_INF: begin
                    s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end
                CLS_ZERO: begin
                    s3_result_d = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                end
                default: begin
                    if (rnd_ovf) begin
                        s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        s3_ovf_d    = 1'b1;
                    end else if (rnd_unf) begin
                        s3_result_d = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                        s3_unf_d    = 1'b1;
                    end else begin
                        s3_result_d = {s2_sign_q, rnd_exp, rnd_frac};
                    end
                end
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_cls_q    <= CLS_NORMAL;
            s1_exp_q    <= '0;
            s1_man_a_q  <= '0;
            s1_man_b_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= CLS_NORMAL;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_result_q <= '0;
            s3_exc_q    <= 1'b0;
            s3_ovf_q    <= 1'b0;
            s3_unf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_cls_q    <= s1_cls_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_a_q  <= s1_man_a_d;
            s1_man_b_q  <= s1_man_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_cls_q    <= s2_cls_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s3_valid_q  <= s3_valid_d;
            s3_result_q <= s3_result_d;
            s3_exc_q    <= s3_exc_d;
            s3_ovf_q    <= s3_ovf_d;
            s3_unf_q    <= s3_unf_d;
        end
    end

    always_comb begin
        out_valid = s3_valid_q;
        result    = s3_result_q;
        exception = s3_exc_q;
        overflow  = s3_ovf_q;
        underflow = s3_unf_q;
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed self-checking bench for fp_mul_pipe (half precision).
module tb_fp_mul_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_operand;
    logic [W-1:0] b_operand;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         exception;
    logic         overflow;
    logic         underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Drives one operation into an idle pipeline and returns what comes out.
    // lat counts rising edges from the accepting edge to out_valid (bounded).
    task automatic run_single(input logic [15:0] a, input logic [15:0] b,
                              output logic [15:0] res, output logic [2:0] flg,
                              output int lat);
        in_valid  = 1'b1;
        a_operand = a;
        b_operand = b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        flg = {exception, overflow, underflow};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        a_operand = 16'h3C00;
        b_operand = 16'h3C00;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready_early: got %b expected 0", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL rst_result: got %h expected 0000", result);
        end
        checks++;
        if ({exception, overflow, underflow} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b expected 000", {exception, overflow, underflow});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready: got %b expected 0", in_ready);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        run_single(16'h3E00, 16'h3E00, res, flg, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", lat);
        end
        checks++;
        if (res !== 16'h4080) begin
            errors++;
            $display("FAIL basic_result: got %h expected 4080", res);
        end
        checks++;
        if (flg !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b expected 000", flg);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] va[2] = '{16'h3C01, 16'h3C01};
        logic [15:0] vb[2] = '{16'h3C01, 16'h3E00};
        logic [15:0] ve[2] = '{16'h3C02, 16'h3E02};
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            run_single(va[i], vb[i], res, flg, lat);
            checks++;
            if (res !== ve[i] || flg !== 3'b000 || lat !== 3) begin
                errors++;
                $display("FAIL rne_%0d: got %h flags %b lat %0d expected %h flags 000 lat 3",
                         i, res, flg, lat, ve[i]);
            end
        end
    endtask

    task automatic test_ovf_unf();
        logic [15:0] va[3] = '{16'h7BFF, 16'h0400, 16'h8400};
        logic [15:0] vb[3] = '{16'h4000, 16'h0400, 16'h0400};
        logic [15:0] ve[3] = '{16'h7C00, 16'h0000, 16'h8000};
        logic [2:0]  vf[3] = '{3'b010, 3'b001, 3'b001};
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_single(va[i], vb[i], res, flg, lat);
            checks++;
            if (res !== ve[i]) begin
                errors++;
                $display("FAIL range_result_%0d: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (flg !== vf[i]) begin
                errors++;
                $display("FAIL range_flags_%0d: got %b expected %b", i, flg, vf[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] va[3] = '{16'h7C00, 16'h7C00, 16'h7E01};
        logic [15:0] vb[3] = '{16'h0000, 16'hC000, 16'h3C00};
        logic [15:0] ve[3] = '{16'h7E00, 16'hFC00, 16'h7E00};
        logic [2:0]  vf[3] = '{3'b100, 3'b000, 3'b100};
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_single(va[i], vb[i], res, flg, lat);
            checks++;
            if (res !== ve[i]) begin
                errors++;
                $display("FAIL special_result_%0d: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (flg !== vf[i]) begin
                errors++;
                $display("FAIL special_flags_%0d: got %b expected %b", i, flg, vf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[4] = '{16'h3E00, 16'h3C01, 16'h3C01, 16'h3C00};
        logic [15:0] tb[4] = '{16'h3E00, 16'h3C01, 16'h3E00, 16'h4000};
        logic [15:0] te[4] = '{16'h4080, 16'h3C02, 16'h3E02, 16'h4000};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_operand = ta[0];
        b_operand = tb[0];
        for (int k = 1; k <= 6; k++) begin
            if (in_valid === 1'b1) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready_%0d: got %b expected 1", k, in_ready);
                end
            end
            @(posedge clk); #1;
            if (k >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || result !== te[k-3]) begin
                    errors++;
                    $display("FAIL b2b_out_%0d: got valid %b result %h expected valid 1 result %h",
                             k - 3, out_valid, result, te[k-3]);
                end
            end
            if (k < 4) begin
                a_operand = ta[k];
                b_operand = tb[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pa[4] = '{16'h3C00, 16'h4000, 16'h3E00, 16'hC000};
        logic [15:0] pb[4] = '{16'h3C00, 16'h4000, 16'h3E00, 16'h3E00};
        logic [15:0] pe[4] = '{16'h3C00, 16'h4400, 16'h4080, 16'hC200};
        logic [15:0] held;
        logic [15:0] got[4];
        int          idx;
        int          n;
        idx = 0;
        held = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_operand = pa[0];
        b_operand = pb[0];
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (in_ready !== (c <= 3)) begin
                errors++;
                $display("FAIL bp_in_ready_c%0d: got %b expected %b", c, in_ready, (c <= 3));
            end
            if (in_ready === 1'b1 && idx < 3) idx++;
            @(posedge clk); #1;
            a_operand = pa[idx];
            b_operand = pb[idx];
            if (c == 4) held = result;
        end
        checks++;
        if (idx !== 3) begin
            errors++;
            $display("FAIL bp_accepted: got %0d expected 3", idx);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== pe[0] || held !== pe[0]) begin
            errors++;
            $display("FAIL bp_hold: got valid %b result %h earlier %h expected valid 1 result %h",
                     out_valid, result, held, pe[0]);
        end
        // Full pipeline: pop and push in the same cycle.
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_full_push_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1) begin
                if (n < 4) got[n] = result;
                n++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d expected 3", n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== pe[i+1]) begin
                errors++;
                $display("FAIL bp_drain_%0d: got %h expected %h", i, got[i], pe[i+1]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        int          bad;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_operand = 16'h3E00;
        b_operand = 16'h3E00;
        @(posedge clk); #1;
        a_operand = 16'h3C01;
        b_operand = 16'h3C01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_rst_discard: got %0d cycles with out_valid expected 0", bad);
        end
        run_single(16'h4000, 16'h4000, res, flg, lat);
        checks++;
        if (res !== 16'h4400 || flg !== 3'b000) begin
            errors++;
            $display("FAIL mid_rst_next: got %h flags %b expected 4400 flags 000", res, flg);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL mid_rst_latency: got %0d expected 3", lat);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_operand = '0;
        b_operand = '0;
        test_reset();
        test_basic();
        test_rounding();
        test_ovf_unf();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
